// File: rtl/peg_pkt_sink_buf.sv
// Store-and-forward packet sink: buffers ingress packets, drops bad or oversized ones, re-emits good ones.
// Optional statistics counters are enabled with `define PEG_PKT_SINK_STATS_EN.
module peg_pkt_sink_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2048
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_sop,
    input  logic                     in_eop,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_error,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_error,
    input  logic                     out_ready,
    output logic                     pkt_drop,
    output logic [$clog2(DEPTH):0]   fill_level
`ifdef PEG_PKT_SINK_STATS_EN
    ,
    input  logic                     clr_stats,
    output logic [31:0]              good_cnt,
    output logic [31:0]              drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] ONE     = PW'(1);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PKT  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [WIDTH+1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, commit_ptr, rd_ptr;
    logic [PW-1:0]    wr_nxt, commit_nxt;
    logic [1:0]       state, state_nxt;
    logic [AW-1:0]    mem_waddr;
    logic             mem_we, drop_now, commit_now;
    logic             full, overflow, accept, load;

    assign full       = (wr_ptr - rd_ptr) == DEPTH_P;
    // An open packet that already fills the whole buffer can never be committed;
    // keep accepting so the overflow beat is taken and the packet is discarded.
    assign overflow   = (state == S_PKT) && full && (commit_ptr == rd_ptr);
    assign in_ready   = (state == S_DROP) || !full || overflow;
    assign accept     = in_valid && in_ready;
    assign fill_level = wr_ptr - rd_ptr;
    assign out_error  = 1'b0;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_nxt  = state;
        wr_nxt     = wr_ptr;
        commit_nxt = commit_ptr;
        mem_we     = 1'b0;
        mem_waddr  = wr_ptr[AW-1:0];
        drop_now   = 1'b0;
        commit_now = 1'b0;
        if (accept) begin
            case (state)
                S_IDLE: begin
                    if (in_sop) begin
                        if (!in_eop) begin
                            mem_we    = 1'b1;
                            wr_nxt    = wr_ptr + ONE;
                            state_nxt = S_PKT;
                        end else if (!in_error) begin
                            mem_we     = 1'b1;
                            wr_nxt     = wr_ptr + ONE;
                            commit_nxt = wr_ptr + ONE;
                            commit_now = 1'b1;
                        end else begin
                            drop_now = 1'b1;
                        end
                    end
                end
                S_PKT: begin
                    if (overflow) begin
                        wr_nxt    = commit_ptr;
                        drop_now  = 1'b1;
                        state_nxt = in_eop ? S_IDLE : S_DROP;
                    end else if (in_sop) begin
                        // Unterminated packet: discard it and restart at the commit point.
                        drop_now  = 1'b1;
                        mem_waddr = commit_ptr[AW-1:0];
                        if (!in_eop) begin
                            mem_we = 1'b1;
                            wr_nxt = commit_ptr + ONE;
                        end else if (!in_error) begin
                            mem_we     = 1'b1;
                            wr_nxt     = commit_ptr + ONE;
                            commit_nxt = commit_ptr + ONE;
                            commit_now = 1'b1;
                            state_nxt  = S_IDLE;
                        end else begin
                            wr_nxt    = commit_ptr;
                            state_nxt = S_IDLE;
                        end
                    end else if (in_eop && in_error) begin
                        wr_nxt    = commit_ptr;
                        drop_now  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        mem_we = 1'b1;
                        wr_nxt = wr_ptr + ONE;
                        if (in_eop) begin
                            commit_nxt = wr_ptr + ONE;
                            commit_now = 1'b1;
                            state_nxt  = S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (in_eop) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: the storage array has no reset; pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= {in_sop, in_eop, in_data};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            pkt_drop   <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_nxt;
            commit_ptr <= commit_nxt;
            pkt_drop   <= drop_now;
        end
    end

    assign load = (commit_ptr != rd_ptr) && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            {out_sop, out_eop, out_data} <= mem[rd_ptr[AW-1:0]];
            out_valid <= 1'b1;
            rd_ptr    <= rd_ptr + ONE;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef PEG_PKT_SINK_STATS_EN
    // Saturating counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt <= '0;
            drop_cnt <= '0;
        end else if (clr_stats) begin
            good_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (commit_now && (good_cnt != 32'hFFFF_FFFF)) good_cnt <= good_cnt + 32'd1;
            if (drop_now && (drop_cnt != 32'hFFFF_FFFF)) drop_cnt <= drop_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_peg_pkt_sink_buf.sv
// Directed bench for peg_pkt_sink_buf: a large-buffer and a 16-entry instance, selected by sel.
module tb_peg_pkt_sink_buf;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } beat_t;

    typedef struct {
        bit         sel;
        int         len;
        bit         err;
        logic [7:0] base;
        int         exp_beats;
        int         exp_drops;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, sel;
    logic       in_valid, in_sop, in_eop, in_error, out_ready;
    logic [7:0] in_data;

    logic       a_in_ready, a_out_valid, a_out_sop, a_out_eop, a_out_error, a_pkt_drop;
    logic [7:0] a_out_data;
    logic [7:0] a_fill;
    logic       b_in_ready, b_out_valid, b_out_sop, b_out_eop, b_out_error, b_pkt_drop;
    logic [7:0] b_out_data;
    logic [4:0] b_fill;
`ifdef PEG_PKT_SINK_STATS_EN
    logic [31:0] a_good, a_dcnt, b_good, b_dcnt;
`endif

    peg_pkt_sink_buf #(.WIDTH(8), .DEPTH(128)) u_big (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & ~sel), .in_sop(in_sop), .in_eop(in_eop),
        .in_data(in_data), .in_error(in_error), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_sop(a_out_sop), .out_eop(a_out_eop),
        .out_data(a_out_data), .out_error(a_out_error), .out_ready(out_ready & ~sel),
        .pkt_drop(a_pkt_drop), .fill_level(a_fill)
`ifdef PEG_PKT_SINK_STATS_EN
        , .clr_stats(1'b0), .good_cnt(a_good), .drop_cnt(a_dcnt)
`endif
    );

    peg_pkt_sink_buf #(.WIDTH(8), .DEPTH(16)) u_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & sel), .in_sop(in_sop), .in_eop(in_eop),
        .in_data(in_data), .in_error(in_error), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_sop(b_out_sop), .out_eop(b_out_eop),
        .out_data(b_out_data), .out_error(b_out_error), .out_ready(out_ready & sel),
        .pkt_drop(b_pkt_drop), .fill_level(b_fill)
`ifdef PEG_PKT_SINK_STATS_EN
        , .clr_stats(1'b0), .good_cnt(b_good), .drop_cnt(b_dcnt)
`endif
    );

    logic        in_ready, out_valid, out_sop, out_eop, out_error, pkt_drop;
    logic [7:0]  out_data;
    logic [15:0] fill_level;
    assign in_ready   = sel ? b_in_ready  : a_in_ready;
    assign out_valid  = sel ? b_out_valid : a_out_valid;
    assign out_sop    = sel ? b_out_sop   : a_out_sop;
    assign out_eop    = sel ? b_out_eop   : a_out_eop;
    assign out_error  = sel ? b_out_error : a_out_error;
    assign out_data   = sel ? b_out_data  : a_out_data;
    assign pkt_drop   = sel ? b_pkt_drop  : a_pkt_drop;
    assign fill_level = sel ? 16'(b_fill) : 16'(a_fill);

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int eop_cyc = 0;
    int first_valid_cyc = -1;
    int drops = 0;
    beat_t got_q[$];
    beat_t mb;

    always @(posedge clk) cyc <= cyc + 1;

    // Egress monitor and drop counter, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            mb.sop  = out_sop;
            mb.eop  = out_eop;
            mb.data = out_data;
            got_q.push_back(mb);
        end
        if (rst_n && out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (rst_n && pkt_drop) drops++;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, got hang required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] bv(input logic s, input logic e, input logic [7:0] d);
        return {22'd0, s, e, d};
    endfunction

    // Present one beat and hold it until accepted; returns with the beat transferred.
    task automatic send_beat(input logic s, input logic e, input logic [7:0] d,
                             input logic err, output int stall);
        stall    = 0;
        in_valid = 1'b1;
        in_sop   = s;
        in_eop   = e;
        in_data  = d;
        in_error = err;
        @(negedge clk);
        while (!in_ready && stall < 200) begin
            stall++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles required 1", stall);
        end
        eop_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_error = 1'b0;
    endtask

    task automatic send_pkt(input int len, input logic [7:0] base, input logic err, output int stalls);
        int st;
        stalls = 0;
        for (int i = 0; i < len; i++) begin
            send_beat(i == 0, i == len - 1, 8'(base + i), err && (i == len - 1), st);
            stalls += st;
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        drops = 0;
        first_valid_cyc = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_sop"}, 32'(out_sop), 32'd0);
        check({tag, "_out_eop"}, 32'(out_eop), 32'd0);
        check({tag, "_out_error"}, 32'(out_error), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_pkt_drop"}, 32'(pkt_drop), 32'd0);
        check({tag, "_fill"}, 32'(fill_level), 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        int st, acc;
        vecs[0] = '{1'b0, 64, 1'b0, 8'h00, 64, 0};   // 64-byte good packet
        vecs[1] = '{1'b0, 20, 1'b1, 8'h40,  0, 1};   // errored packet
        vecs[2] = '{1'b0,  1, 1'b0, 8'hC3,  1, 0};   // single-beat good
        vecs[3] = '{1'b0,  1, 1'b1, 8'h11,  0, 1};   // single-beat errored
        vecs[4] = '{1'b1, 20, 1'b0, 8'h60,  0, 1};   // overflow: drops at beat 17
        vecs[5] = '{1'b1,  4, 1'b0, 8'h80,  4, 0};   // delivered after the overflow
        vecs[6] = '{1'b1, 16, 1'b0, 8'h90, 16, 0};   // exactly fills the buffer
        vecs[7] = '{1'b1, 17, 1'b0, 8'hB0,  0, 1};   // one beat too many, eop on overflow

        rst_n = 1'b0; sel = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0; in_data = 8'h00;
        #12;
        check_reset_outputs("rst_big");
        sel = 1'b1;
        #1;
        check_reset_outputs("rst_small");
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int v = 0; v < 8; v++) begin
            sel = vecs[v].sel;
            @(posedge clk);
            #1;
            clear_mon();
            send_pkt(vecs[v].len, vecs[v].base, vecs[v].err, st);
            repeat (vecs[v].len + 8) @(negedge clk);
            check($sformatf("v%0d_stalls", v), 32'(st), 32'd0);
            check($sformatf("v%0d_beats", v), 32'(got_q.size()), 32'(vecs[v].exp_beats));
            check($sformatf("v%0d_drops", v), 32'(drops), 32'(vecs[v].exp_drops));
            check($sformatf("v%0d_fill", v), 32'(fill_level), 32'd0);
            if (vecs[v].exp_beats > 0)
                check($sformatf("v%0d_latency", v), 32'(first_valid_cyc - eop_cyc), 32'd2);
            for (int i = 0; i < vecs[v].exp_beats && i < got_q.size(); i++)
                check($sformatf("v%0d_beat%0d", v, i),
                      bv(got_q[i].sop, got_q[i].eop, got_q[i].data),
                      bv(i == 0, i == vecs[v].len - 1, 8'(vecs[v].base + i)));
            @(posedge clk);
            #1;
        end

        // Backpressure on the 16-entry buffer.
        sel = 1'b1;
        out_ready = 1'b0;
        clear_mon();
        send_pkt(10, 8'h10, 1'b0, st);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        check("bp_head_held", bv(out_valid, out_sop, out_data), bv(1'b1, 1'b1, 8'h10));
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_sop = (i == 0); in_eop = (i == 7);
            in_error = 1'b0; in_data = 8'(8'h20 + i);
            @(negedge clk);
            if (!in_ready) break;
            @(posedge clk);
            #1;
            acc++;
        end
        // The head beat already sits in the output register, freeing one entry.
        check("bp_accepted", 32'(acc), 32'd7);
        check("bp_fill_full", 32'(fill_level), 32'd16);
        repeat (3) @(negedge clk);
        check("bp_still_stalled", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = acc; i < 8; i++) send_beat(i == 0, i == 7, 8'(8'h20 + i), 1'b0, st);
        repeat (30) @(negedge clk);
        check("bp_beats", 32'(got_q.size()), 32'd18);
        for (int i = 0; i < 10 && i < got_q.size(); i++)
            check($sformatf("bp_p1_beat%0d", i), bv(got_q[i].sop, got_q[i].eop, got_q[i].data),
                  bv(i == 0, i == 9, 8'(8'h10 + i)));
        for (int j = 0; j < 8 && (10 + j) < got_q.size(); j++)
            check($sformatf("bp_p2_beat%0d", j),
                  bv(got_q[10+j].sop, got_q[10+j].eop, got_q[10+j].data),
                  bv(j == 0, j == 7, 8'(8'h20 + j)));
        check("bp_drops", 32'(drops), 32'd0);
        check("bp_fill_end", 32'(fill_level), 32'd0);

        // sop arriving mid-packet, then a good 3-byte packet.
        @(posedge clk);
        #1;
        sel = 1'b0;
        clear_mon();
        for (int i = 0; i < 5; i++) send_beat(i == 0, 1'b0, 8'(8'h30 + i), 1'b0, st);
        send_pkt(3, 8'h50, 1'b0, st);
        repeat (20) @(negedge clk);
        check("midsop_drops", 32'(drops), 32'd1);
        check("midsop_beats", 32'(got_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < got_q.size(); i++)
            check($sformatf("midsop_beat%0d", i), bv(got_q[i].sop, got_q[i].eop, got_q[i].data),
                  bv(i == 0, i == 2, 8'(8'h50 + i)));

        // Reset asserted while a 32-byte packet streams out.
        @(posedge clk);
        #1;
        clear_mon();
        send_pkt(32, 8'h00, 1'b0, st);
        for (int i = 0; i < 100 && got_q.size() < 10; i++) @(negedge clk);
        check("rst_mid_progress", 32'(got_q.size() >= 10), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_fill", 32'(fill_level), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_pkt_drop", 32'(pkt_drop), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_mon();
        send_beat(1'b1, 1'b1, 8'hA5, 1'b0, st);
        repeat (10) @(negedge clk);
        check("post_rst_beats", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0)
            check("post_rst_beat", bv(got_q[0].sop, got_q[0].eop, got_q[0].data),
                  bv(1'b1, 1'b1, 8'hA5));
        check("post_rst_latency", 32'(first_valid_cyc - eop_cyc), 32'd2);
        check("post_rst_drops", 32'(drops), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
